// File: rtl/ultimate_ctrl_if.sv
// Signal bundle between the ultimate-attack controller and the rest of the game:
// energy/keyboard/player inputs, pixel position, beam outputs and handshakes.
interface ultimate_ctrl_if;
    logic       energy_ready;
    logic       fire_key;
    logic [9:0] player_x;
    logic [9:0] player_y;
    logic       facing;
    logic       interrupt;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       reset_energy;
    logic       ult_active;
    logic       ult_busy;
    logic [9:0] beam_x;
    logic [9:0] beam_y;
    logic       is_ult;

    modport master (
        output energy_ready, fire_key, player_x, player_y, facing, interrupt, DrawX, DrawY,
        input  reset_energy, ult_active, ult_busy, beam_x, beam_y, is_ult
    );

    modport slave (
        input  energy_ready, fire_key, player_x, player_y, facing, interrupt, DrawX, DrawY,
        output reset_energy, ult_active, ult_busy, beam_x, beam_y, is_ult
    );
endinterface

// File: rtl/ultimate_ctrl.sv
// Player special attack sequencer: wind-up, travelling beam, cooldown, energy reset pulse.
// Define ULT_CANCEL_EN to let a hit during the wind-up abort the attack.
module ultimate_ctrl #(
    parameter logic [9:0] CHARGE_FRAMES = 10'd20,
    parameter logic [9:0] COOL_FRAMES   = 10'd60,
    parameter logic [9:0] SPEED         = 10'd8,
    parameter logic [9:0] BEAM_W        = 10'd32,
    parameter logic [9:0] BEAM_H        = 10'd16,
    parameter logic [9:0] X_MIN         = 10'd0,
    parameter logic [9:0] X_MAX         = 10'd639
) (
    input logic            frame_clk,
    input logic            reset,
    ultimate_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, CHARGE, ACTIVE, COOLDOWN} state_t;

    // A zero-length wind-up or cooldown still lasts one frame.
    localparam logic [9:0] CHARGE_LAST = (CHARGE_FRAMES == 10'd0) ? 10'd0 : CHARGE_FRAMES - 10'd1;
    localparam logic [9:0] COOL_LAST   = (COOL_FRAMES == 10'd0) ? 10'd0 : COOL_FRAMES - 10'd1;

    state_t     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic [9:0] beam_x_q, beam_x_d;
    logic [9:0] beam_y_q, beam_y_d;
    logic       dir_q, dir_d;
    logic       fire_key_prev_q, fire_key_prev_d;
    logic       reset_energy_q, reset_energy_d;
    logic       ult_active_q, ult_active_d;
    logic       ult_busy_q, ult_busy_d;

    logic       fire_req;
    logic       hit_right;
    logic       hit_left;

    // Spawn point for a left-facing beam; clamps at the left bound instead of wrapping.
    function automatic logic [9:0] spawn_left(input logic [9:0] px);
        if ({1'b0, px} < ({1'b0, X_MIN} + {1'b0, BEAM_W}))
            return X_MIN;
        else
            return px - BEAM_W;
    endfunction

    assign fire_req  = bus.fire_key & ~fire_key_prev_q;
    assign hit_right = ({1'b0, beam_x_q} + {1'b0, SPEED}) > ({1'b0, X_MAX} - {1'b0, BEAM_W} + 11'd1);
    assign hit_left  = {1'b0, beam_x_q} < ({1'b0, X_MIN} + {1'b0, SPEED});

`ifndef ULT_CANCEL_EN
    logic unused_interrupt;
    assign unused_interrupt = bus.interrupt;
`endif

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        beam_x_d        = beam_x_q;
        beam_y_d        = beam_y_q;
        dir_d           = dir_q;
        fire_key_prev_d = bus.fire_key;
        reset_energy_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (fire_req && bus.energy_ready) begin
                    state_d        = CHARGE;
                    dir_d          = bus.facing;
                    beam_y_d       = bus.player_y;
                    beam_x_d       = bus.facing ? spawn_left(bus.player_x) : bus.player_x;
                    reset_energy_d = 1'b1;
                    cnt_d          = 10'd0;
                end
            end
            CHARGE: begin
                if (cnt_q >= CHARGE_LAST) begin
                    state_d = ACTIVE;
                    cnt_d   = 10'd0;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
`ifdef ULT_CANCEL_EN
                if (bus.interrupt) begin
                    state_d = COOLDOWN;
                    cnt_d   = 10'd0;
                end
`endif
            end
            ACTIVE: begin
                // The frame that sees the edge keeps the beam where it is.
                if (dir_q ? hit_left : hit_right) begin
                    state_d = COOLDOWN;
                    cnt_d   = 10'd0;
                end else begin
                    beam_x_d = dir_q ? (beam_x_q - SPEED) : (beam_x_q + SPEED);
                end
            end
            COOLDOWN: begin
                if (cnt_q >= COOL_LAST) begin
                    state_d = IDLE;
                    cnt_d   = 10'd0;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        ult_active_d = (state_d == ACTIVE);
        ult_busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge frame_clk) begin
        if (reset) begin
            state_q         <= IDLE;
            cnt_q           <= 10'd0;
            beam_x_q        <= 10'd0;
            beam_y_q        <= 10'd0;
            dir_q           <= 1'b0;
            fire_key_prev_q <= 1'b0;
            reset_energy_q  <= 1'b0;
            ult_active_q    <= 1'b0;
            ult_busy_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            beam_x_q        <= beam_x_d;
            beam_y_q        <= beam_y_d;
            dir_q           <= dir_d;
            fire_key_prev_q <= fire_key_prev_d;
            reset_energy_q  <= reset_energy_d;
            ult_active_q    <= ult_active_d;
            ult_busy_q      <= ult_busy_d;
        end
    end

    assign bus.reset_energy = reset_energy_q;
    assign bus.ult_active   = ult_active_q;
    assign bus.ult_busy     = ult_busy_q;
    assign bus.beam_x       = beam_x_q;
    assign bus.beam_y       = beam_y_q;

    assign bus.is_ult = (state_q == ACTIVE)
                      && ({1'b0, bus.DrawX} >= {1'b0, beam_x_q})
                      && ({1'b0, bus.DrawX} <= ({1'b0, beam_x_q} + {1'b0, BEAM_W} - 11'd1))
                      && ({1'b0, bus.DrawY} >= {1'b0, beam_y_q})
                      && ({1'b0, bus.DrawY} <= ({1'b0, beam_y_q} + {1'b0, BEAM_H} - 11'd1));

endmodule

// File: tb/tb_ultimate_ctrl.sv
// Scoreboard bench for ultimate_ctrl: a per-attack plan model predicts every frame's outputs.
module tb_ultimate_ctrl;

    localparam int PH_IDLE = 0;
    localparam int PH_CHG  = 1;
    localparam int PH_ACT  = 2;
    localparam int PH_COOL = 3;

    logic frame_clk = 1'b0;
    logic reset;

    ultimate_ctrl_if bus();

    ultimate_ctrl dut (
        .frame_clk (frame_clk),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        bit re;
        bit act;
        bit busy;
        int bx;
        int by;
        bit ul;
        int ph;
    } exp_t;

    exp_t exp_q[$];
    exp_t plan[$];
    exp_t cur;
    bit   fire_prev;
    int   n_checks;
    int   n_fail;

    function automatic exp_t mk(bit re, int ph, int bx, int by);
        exp_t e;
        e.re   = re;
        e.ph   = ph;
        e.act  = (ph == PH_ACT);
        e.busy = (ph != PH_IDLE);
        e.bx   = bx;
        e.by   = by;
        e.ul   = 1'b0;
        return e;
    endfunction

    // Whole attack laid out at fire time: 20 wind-up frames, the beam's path, 60 lockout frames.
    task automatic build_plan(input int px, input int py, input bit fc);
        int x;
        x = fc ? ((px >= 32) ? px - 32 : 0) : px;
        for (int i = 0; i < 20; i++) plan.push_back(mk(i == 0, PH_CHG, x, py));
        while (1) begin
            plan.push_back(mk(1'b0, PH_ACT, x, py));
            if (!fc) begin
                if (x + 8 > 608) break;
                x = x + 8;
            end else begin
                if (x < 8) break;
                x = x - 8;
            end
        end
        for (int i = 0; i < 60; i++) plan.push_back(mk(1'b0, PH_COOL, x, py));
    endtask

    task automatic model_step(input bit rst, input bit fk, input bit er, input bit fc,
                              input bit irq, input int px, input int py, output exp_t e);
        bit fire_req;
        if (rst) begin
            plan.delete();
            fire_prev = 1'b0;
            e = mk(1'b0, PH_IDLE, 0, 0);
        end else begin
            fire_req  = fk && !fire_prev;
            fire_prev = fk;
            if (cur.ph == PH_IDLE && fire_req && er) build_plan(px, py, fc);
`ifdef ULT_CANCEL_EN
            if (cur.ph == PH_CHG && irq) begin
                plan.delete();
                for (int i = 0; i < 60; i++) plan.push_back(mk(1'b0, PH_COOL, cur.bx, cur.by));
            end
`endif
            if (plan.size() > 0) e = plan.pop_front();
            else e = mk(1'b0, PH_IDLE, cur.bx, cur.by);
        end
        cur = e;
        if (irq) e.ul = 1'b0;
    endtask

    function automatic int pick(int base, int span);
        int v;
        case ($urandom_range(0, 4))
            0:       v = base;
            1:       v = base + span - 1;
            2:       v = base + span;
            3:       v = base - 1;
            default: v = int'($urandom_range(0, 1023));
        endcase
        return v & 1023;
    endfunction

    task automatic drive(input bit rst, input bit fk, input bit er, input bit fc,
                         input bit irq, input int px, input int py);
        exp_t e;
        int   dx, dy;
        @(negedge frame_clk);
        reset            = rst;
        bus.fire_key     = fk;
        bus.energy_ready = er;
        bus.facing       = fc;
        bus.interrupt    = irq;
        bus.player_x     = px[9:0];
        bus.player_y     = py[9:0];
        model_step(rst, fk, er, fc, irq, px, py, e);
        dx = pick(e.bx, 32);
        dy = pick(e.by, 16);
        bus.DrawX = dx[9:0];
        bus.DrawY = dy[9:0];
        e.ul = e.act && (dx >= e.bx) && (dx <= e.bx + 31) && (dy >= e.by) && (dy <= e.by + 15);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, expv, $time);
        end
    endtask

    // Monitor: every frame the DUT presents a fresh set of registered outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge frame_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("reset_energy", int'(bus.reset_energy), int'(e.re));
                chk("ult_active",   int'(bus.ult_active),   int'(e.act));
                chk("ult_busy",     int'(bus.ult_busy),     int'(e.busy));
                chk("beam_x",       int'(bus.beam_x),       e.bx);
                chk("beam_y",       int'(bus.beam_y),       e.by);
                chk("is_ult",       int'(bus.is_ult),       int'(e.ul));
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        fire_prev = 1'b0;
        cur = mk(1'b0, PH_IDLE, 0, 0);
        reset = 1'b1;
        bus.fire_key = 1'b0;
        bus.energy_ready = 1'b0;
        bus.facing = 1'b0;
        bus.interrupt = 1'b0;
        bus.player_x = '0;
        bus.player_y = '0;
        bus.DrawX = '0;
        bus.DrawY = '0;

        repeat (3) drive(1, 0, 0, 0, 0, 0, 0);

        // Fire from rest at frame 5; player moves during wind-up and must not be re-sampled.
        repeat (5) drive(0, 0, 1, 0, 0, 100, 50);
        drive(0, 1, 1, 0, 0, 100, 50);
        repeat (170) drive(0, 0, 1, 1, 0, 300, 400);

        // Fire pulses with no energy.
        for (int i = 0; i < 10; i++) drive(0, i[0], 0, 0, 0, 120, 60);
        drive(0, 0, 0, 0, 0, 120, 60);

        // Held key: one attack only, then release and press again.
        repeat (200) drive(0, 1, 1, 0, 0, 100, 80);
        repeat (2) drive(0, 0, 1, 0, 0, 100, 80);
        drive(0, 1, 1, 0, 0, 100, 80);
        repeat (160) drive(0, 0, 1, 0, 0, 100, 80);

        // Right edge from 600, left edge from 20.
        drive(0, 1, 1, 0, 0, 600, 100);
        repeat (90) drive(0, 0, 1, 0, 0, 600, 100);
        drive(0, 1, 1, 1, 0, 20, 200);
        repeat (90) drive(0, 0, 1, 1, 0, 20, 200);

        // Pixel window around a beam spawned at (200,300).
        drive(0, 1, 1, 0, 0, 200, 300);
        repeat (140) drive(0, 0, 1, 0, 0, 200, 300);

        // Reset in the middle of the beam.
        drive(0, 1, 1, 0, 0, 100, 50);
        repeat (25) drive(0, 0, 1, 0, 0, 100, 50);
        drive(1, 0, 1, 0, 0, 100, 50);
        repeat (5) drive(0, 0, 1, 0, 0, 100, 50);

        // Interrupt on the fifth wind-up frame.
        drive(0, 1, 1, 1, 0, 400, 250);
        repeat (4) drive(0, 0, 1, 1, 0, 400, 250);
        drive(0, 0, 1, 1, 1, 400, 250);
        repeat (150) drive(0, 0, 1, 1, 0, 400, 250);

        // Randomised play.
        begin
            bit fk;
            fk = 1'b0;
            for (int i = 0; i < 2500; i++) begin
                if ($urandom_range(0, 3) == 0) fk = ~fk;
                drive(($urandom_range(0, 299) == 0), fk, ($urandom_range(0, 9) < 7),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                      int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
            end
        end

        repeat (2) @(negedge frame_clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
